alu_src_ctrl_fsm: RTL and testbench
===================================

// Module: alu_src_ctrl_fsm
// PURPOSE
//  Multicycle control sequencer that drives the ALU operand-select muxes
//  (alu_srcA 2:1, alu_srcB 4:1) and the datapath write strobes.
//  Decodes opcode/funct from the IR and steps FETCH/DECODE/EXEC/MEM/WB states.
//  alu_srcB encoding matches the ALU B-operand mux:
//  11=const 4, 10=reg B, 01=sign-ext imm, 00=sign-ext imm<<2.
// PARAMETERS
//  MEM_WAIT  2  extra wait cycles per memory read (0..15); read phase = MEM_WAIT+1 cycles
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-low reset
//  opcode         in   6  IR[31:26]
//  funct          in   6  IR[5:0], informational only (ALU decodes it when alu_op=10)
//  alu_zero       in   1  ALU zero flag, used in BEQ state
//  alu_srcA       out  1  0=PC, 1=reg A
//  alu_srcB       out  2  see PURPOSE encoding
//  alu_op         out  2  00=ADD, 01=SUB, 10=use funct
//  pc_write       out  1  unconditional PC load
//  pc_src         out  2  00=ALU result, 01=ALUOut, 10=jump target
//  ir_write       out  1  IR load
//  ab_load        out  1  load A/B regs
//  mem_read       out  1  memory read request
//  mem_write      out  1  memory write strobe
//  reg_write      out  1  register-file write
//  reg_dst        out  1  0=rt, 1=rd
//  mem_to_reg     out  1  0=ALUOut, 1=MDR
//  illegal_op     out  1  one-cycle pulse on undefined opcode
//  state_out      out  4  current state code (debug)
// BEHAVIOUR
//  State reg + wait counter (4b) are the only flops. Outputs are Moore, decoded from state.
//  Unlisted outputs = 0 in every state. Defaults: alu_srcA=0, alu_srcB=00, alu_op=00.
//  reset low: state=RST(0), counter=0, all outputs 0, immediately (async).
//  RST(0): 1 cycle after reset release, then -> FETCH.
//  FETCH(1): mem_read=1, srcA=0, srcB=11, ADD. Stays MEM_WAIT+1 cycles (counter).
//    Last cycle: ir_write=1, pc_write=1, pc_src=00. -> DECODE.
//  DECODE(2): srcA=0, srcB=00, ADD, ab_load=1 (branch target to ALUOut). Next state by opcode:
//    0x00 -> EXEC_R; 0x08 -> ADDI_EX; 0x23/0x2B -> MEM_ADDR; 0x04 -> BEQ;
//    0x02 -> JUMP; else -> ILLEGAL.
//  EXEC_R(3): srcA=1, srcB=10, alu_op=10 -> R_WB(4): reg_write, reg_dst=1 -> FETCH.
//  ADDI_EX(5): srcA=1, srcB=01, ADD -> ADDI_WB(6): reg_write, reg_dst=0 -> FETCH.
//  MEM_ADDR(7): srcA=1, srcB=01, ADD. Next: LW_READ if opcode 0x23, else SW_WRITE.
//  LW_READ(8): mem_read=1 for MEM_WAIT+1 cycles -> LW_WB(9).
//  LW_WB(9): reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
//  SW_WRITE(10): mem_write=1 exactly 1 cycle -> FETCH.
//  BEQ(11): srcA=1, srcB=10, SUB. pc_write=alu_zero (Mealy exception), pc_src=01 -> FETCH.
//  JUMP(12): pc_write=1, pc_src=10 -> FETCH.
//  ILLEGAL(13): illegal_op=1 for 1 cycle, PC untouched -> FETCH.
//  Codes 14/15 are unreachable; if entered -> RST.
//  Counter: cleared on every state change, increments while in FETCH/LW_READ.
//    Phase exit when counter==MEM_WAIT. With MEM_WAIT=0 the phase is 1 cycle.
//  opcode is sampled only in DECODE and MEM_ADDR; changes elsewhere are ignored.
//  Latency at MEM_WAIT=2: R/ADDI/SW = 6 cycles, LW = 9, BEQ/J/illegal = 5.
//  reset asserted mid-instruction: abort at once, no further strobes, restart at RST.
// TESTING
//  T1 reset low 3 cyc, release -> state 0 for 1 cycle, FETCH next; all strobes 0 during reset.
//  T2 opcode=0x00, MEM_WAIT=2 -> states 1,1,1,2,3,4.
//     ir_write/pc_write only on 3rd FETCH cycle; reg_write+reg_dst=1 on cycle 6.
//  T3 opcode=0x23 -> srcB=01 in MEM_ADDR, mem_read 3 cycles in LW_READ.
//     reg_write+mem_to_reg in LW_WB; total 9 cycles.
//  T4 opcode=0x04, alu_zero=1 then a second BEQ with alu_zero=0
//     -> pc_write=1/pc_src=01 first, pc_write=0 second.
//  T5 opcode=0x3F -> illegal_op pulses exactly 1 cycle in state 13, then FETCH; no reg/mem writes.
//  T6 reset dropped during LW_READ cycle 2 -> mem_read falls same cycle.
//     Recovery: RST then FETCH. Repeat T2 with MEM_WAIT=0 -> 4-cycle R instruction.

Source files
------------

// File: rtl/alu_src_ctrl_fsm.sv
// Multicycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB and decodes the
// ALU operand-select muxes and datapath write strobes from the current state.
module alu_src_ctrl_fsm #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   output logic       alu_srcA,
   output logic [1:0] alu_srcB,
   output logic [1:0] alu_op,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       ab_load,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal_op,
   output logic [3:0] state_out
);

   typedef enum logic [3:0] {
      S_RST      = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_R_WB     = 4'd4,
      S_ADDI_EX  = 4'd5,
      S_ADDI_WB  = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_LW_READ  = 4'd8,
      S_LW_WB    = 4'd9,
      S_SW_WRITE = 4'd10,
      S_BEQ      = 4'd11,
      S_JUMP     = 4'd12,
      S_ILLEGAL  = 4'd13
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       phase_done;

   // funct is decoded by the ALU itself when alu_op selects it.
   logic unused_funct;
   assign unused_funct = ^funct;

   assign phase_done = (cnt_q == WAIT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RST;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Counter only advances inside a memory phase; every state change clears it.
   always_comb begin
      state_d = state_q;
      cnt_d   = 4'd0;
      case (state_q)
         S_RST:      state_d = S_FETCH;
         S_FETCH: begin
            if (phase_done) state_d = S_DECODE;
            else            cnt_d   = cnt_q + 4'd1;
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_d = S_EXEC_R;
               OP_ADDI:      state_d = S_ADDI_EX;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_EXEC_R:   state_d = S_R_WB;
         S_ADDI_EX:  state_d = S_ADDI_WB;
         S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
         S_LW_READ: begin
            if (phase_done) state_d = S_LW_WB;
            else            cnt_d   = cnt_q + 4'd1;
         end
         S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WRITE,
         S_BEQ, S_JUMP, S_ILLEGAL:
                     state_d = S_FETCH;
         default:    state_d = S_RST;
      endcase
   end

   always_comb begin
      alu_srcA   = 1'b0;
      alu_srcB   = 2'b00;
      alu_op     = 2'b00;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      ir_write   = 1'b0;
      ab_load    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            alu_srcB = 2'b11;
            ir_write = phase_done;
            pc_write = phase_done;
         end
         S_DECODE:   ab_load = 1'b1;
         S_EXEC_R: begin
            alu_srcA = 1'b1;
            alu_srcB = 2'b10;
            alu_op   = 2'b10;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_ADDI_EX, S_MEM_ADDR: begin
            alu_srcA = 1'b1;
            alu_srcB = 2'b01;
         end
         S_ADDI_WB:  reg_write = 1'b1;
         S_LW_READ:  mem_read  = 1'b1;
         S_LW_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_SW_WRITE: mem_write = 1'b1;
         // Branch is taken on the same cycle the ALU compares, hence the alu_zero term.
         S_BEQ: begin
            alu_srcA = 1'b1;
            alu_srcB = 2'b10;
            alu_op   = 2'b01;
            pc_write = alu_zero;
            pc_src   = 2'b01;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
         end
         S_ILLEGAL:  illegal_op = 1'b1;
         default: ;
      endcase
   end

   assign state_out = state_q;

endmodule

// File: tb/tb_alu_src_ctrl_fsm.sv
// Directed bench for alu_src_ctrl_fsm: per-cycle state and control-word checks
// against hand-built expected sequences, with a MEM_WAIT=0 instance alongside.
module tb_alu_src_ctrl_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode, op0;
   logic [5:0] funct = 6'h20;
   logic       alu_zero;

   logic       alu_srcA, pc_write, ir_write, ab_load, mem_read, mem_write;
   logic       reg_write, reg_dst, mem_to_reg, illegal_op;
   logic [1:0] alu_srcB, alu_op, pc_src;
   logic [3:0] state_out;

   logic       a0_srcA, a0_pcw, a0_irw, a0_ab, a0_mr, a0_mw, a0_rw, a0_rd, a0_m2r, a0_ill;
   logic [1:0] a0_srcB, a0_op, a0_pcs;
   logic [3:0] a0_state;

   logic [15:0] ctrl, ctrl0;
   logic [3:0]  es[$];
   logic [15:0] ew[$];
   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   alu_src_ctrl_fsm #(.MEM_WAIT(2)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_op(alu_op), .pc_write(pc_write),
      .pc_src(pc_src), .ir_write(ir_write), .ab_load(ab_load), .mem_read(mem_read),
      .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state_out(state_out)
   );

   alu_src_ctrl_fsm #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .reset(reset), .opcode(op0), .funct(funct), .alu_zero(alu_zero),
      .alu_srcA(a0_srcA), .alu_srcB(a0_srcB), .alu_op(a0_op), .pc_write(a0_pcw),
      .pc_src(a0_pcs), .ir_write(a0_irw), .ab_load(a0_ab), .mem_read(a0_mr),
      .mem_write(a0_mw), .reg_write(a0_rw), .reg_dst(a0_rd),
      .mem_to_reg(a0_m2r), .illegal_op(a0_ill), .state_out(a0_state)
   );

   assign ctrl  = {alu_srcA, alu_srcB, alu_op, pc_write, pc_src, ir_write, ab_load,
                   mem_read, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op};
   assign ctrl0 = {a0_srcA, a0_srcB, a0_op, a0_pcw, a0_pcs, a0_irw, a0_ab,
                   a0_mr, a0_mw, a0_rw, a0_rd, a0_m2r, a0_ill};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] cw(input logic sa, input logic [1:0] sb, input logic [1:0] op,
                                      input logic pw, input logic [1:0] ps, input logic irw,
                                      input logic ab, input logic mr, input logic mw,
                                      input logic rw, input logic rd, input logic m2r,
                                      input logic ill);
      return {sa, sb, op, pw, ps, irw, ab, mr, mw, rw, rd, m2r, ill};
   endfunction

   task automatic push(input logic [3:0] s, input logic [15:0] w);
      es.push_back(s);
      ew.push_back(w);
   endtask

   // FETCH cycles (mw waits + last) followed by DECODE
   task automatic push_front(input int mw);
      for (int i = 0; i < mw; i++)
         push(4'd1, cw(0, 2'b11, 2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      push(4'd1, cw(0, 2'b11, 2'b00, 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0));
      push(4'd2, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0));
   endtask

   // Called at a falling edge; opcode is scrambled during FETCH to show it is ignored there.
   task automatic run(input string tag, input logic [5:0] op);
      for (int i = 0; i < es.size(); i++) begin
         check($sformatf("%s c%0d state", tag, i), 32'(state_out), 32'(es[i]));
         check($sformatf("%s c%0d ctrl", tag, i), 32'(ctrl), 32'(ew[i]));
         opcode = (es[i] == 4'd1) ? 6'($urandom_range(0, 63)) : op;
         @(posedge clk);
         @(negedge clk);
      end
      es.delete();
      ew.delete();
   endtask

   initial begin
      logic [3:0]  e0_s[5];
      logic [15:0] e0_w[5];
      logic [3:0]  em_s[5];
      reset    = 1'b0;
      opcode   = 6'h3F;
      op0      = 6'h00;
      alu_zero = 1'b0;

      // T1: reset held low, everything idle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst c%0d state", i), 32'(state_out), 32'd0);
         check($sformatf("rst c%0d ctrl", i), 32'(ctrl), 32'd0);
      end
      reset = 1'b1;
      check("rel state", 32'(state_out), 32'd0);
      check("rel ctrl", 32'(ctrl), 32'd0);
      @(posedge clk);
      @(negedge clk);

      // T2: R-type
      push_front(2);
      push(4'd3, cw(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      push(4'd4, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0));
      run("rtype", 6'h00);

      push_front(2);
      push(4'd5, cw(1, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      push(4'd6, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0));
      run("addi", 6'h08);

      // T3: load word, 9 cycles
      push_front(2);
      push(4'd7, cw(1, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 3; i++)
         push(4'd8, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      push(4'd9, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0));
      run("lw", 6'h23);

      push_front(2);
      push(4'd7, cw(1, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      push(4'd10, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0));
      run("sw", 6'h2B);

      // T4: branch taken then not taken
      alu_zero = 1'b1;
      push_front(2);
      push(4'd11, cw(1, 2'b10, 2'b01, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
      run("beq_t", 6'h04);
      alu_zero = 1'b0;
      push_front(2);
      push(4'd11, cw(1, 2'b10, 2'b01, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
      run("beq_nt", 6'h04);

      push_front(2);
      push(4'd12, cw(0, 2'b00, 2'b00, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
      run("jump", 6'h02);

      // T5: undefined opcode
      push_front(2);
      push(4'd13, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1));
      run("illegal", 6'h3F);
      check("ill after state", 32'(state_out), 32'd1);
      check("ill after pulse", 32'(illegal_op), 32'd0);

      // T6: abort during the second LW_READ cycle
      push_front(2);
      push(4'd7, cw(1, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
      push(4'd8, cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0));
      run("lw_abort", 6'h23);
      check("abort pre state", 32'(state_out), 32'd8);
      check("abort pre mem_read", 32'(mem_read), 32'd1);
      reset = 1'b0;
      #1;
      check("abort mem_read", 32'(mem_read), 32'd0);
      check("abort state", 32'(state_out), 32'd0);
      check("abort ctrl", 32'(ctrl), 32'd0);
      opcode = 6'h00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("abort hold c%0d ctrl", i), 32'(ctrl), 32'd0);
      end
      reset = 1'b1;
      check("recov state", 32'(state_out), 32'd0);
      check("recov mw0 state", 32'(a0_state), 32'd0);
      @(posedge clk);
      @(negedge clk);

      // MEM_WAIT=0 instance: 4-cycle R instruction, then back to FETCH
      e0_s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};
      e0_w[0] = cw(0, 2'b11, 2'b00, 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0);
      e0_w[1] = cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0);
      e0_w[2] = cw(1, 2'b10, 2'b10, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
      e0_w[3] = cw(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
      e0_w[4] = e0_w[0];
      em_s = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3};
      for (int i = 0; i < 5; i++) begin
         check($sformatf("mw0 c%0d state", i), 32'(a0_state), 32'(e0_s[i]));
         check($sformatf("mw0 c%0d ctrl", i), 32'(ctrl0), 32'(e0_w[i]));
         check($sformatf("recov c%0d state", i), 32'(state_out), 32'(em_s[i]));
         @(posedge clk);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
